invader_formation: RTL and testbench

Game-side owner of the invader formation: consumes the per-pixel collision codes and `frame` strobe produced by the VGA controller, and produces the alive mask and formation origin that the controller draws. Marches the formation on frame boundaries, removes hit invaders, and signals laser consumption, scoring, wave clear and game over to the rest of the game logic.

---
 rtl/invader_formation_pkg.sv | 36 +++
 rtl/invader_formation_step_timer.sv | 44 ++++
 rtl/invader_formation.sv | 181 ++++++++++++++++++
 tb/tb_invader_formation.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invader_formation_pkg.sv
// Shared game constants, FSM state encoding and default formation geometry for the invader formation.
package invader_formation_pkg;

   localparam int unsigned INVADERS_H = 11;
   localparam int unsigned INVADERS_V = 5;
   localparam int unsigned N_INVADERS = INVADERS_H * INVADERS_V;
   localparam int unsigned COLL_W     = 6;
   localparam int unsigned POS_W      = 10;
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned LIVES_W    = 2;
   localparam int unsigned LIVES_INIT = 3;

   localparam int unsigned START_X_DEF         = 100;
   localparam int unsigned START_Y_DEF         = 64;
   localparam int unsigned X_MIN_DEF           = 16;
   localparam int unsigned X_MAX_DEF           = 344;
   localparam int unsigned Y_LAND_DEF          = 400;
   localparam int unsigned STEP_X_DEF          = 2;
   localparam int unsigned STEP_Y_DEF          = 8;
   localparam int unsigned FRAMES_PER_STEP_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MARCH_R,
      ST_MARCH_L,
      ST_DROP,
      ST_CLEAR,
      ST_OVER
   } state_t;

   // States in which the formation is live: marching, collisions and frame counting.
   function automatic logic is_active(input state_t s);
      return (s == ST_MARCH_R) || (s == ST_MARCH_L) || (s == ST_DROP);
   endfunction

endpackage

// File: rtl/invader_formation_step_timer.sv
// Frame counter that paces formation steps; INVADER_SPEEDUP_EN shortens the interval as invaders die.
module step_timer
   import invader_formation_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = FRAMES_PER_STEP_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame,
   input  logic              active,
`ifdef INVADER_SPEEDUP_EN
   input  logic [COLL_W-1:0] alive_count,
`endif
   output logic              step_tick
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] interval;

`ifdef INVADER_SPEEDUP_EN
   // Interval is re-latched on every step so a shrinking formation speeds up one step later.
   always_ff @(posedge clk) begin
      if (rst) begin
         interval <= CNT_W'((N_INVADERS >> 2) + 1);
      end else if (step_tick) begin
         interval <= CNT_W'(alive_count >> 2) + CNT_W'(1);
      end
   end
`else
   assign interval = CNT_W'(FRAMES_PER_STEP);
`endif

   // >= rather than == lets the counter wrap early when the interval shrinks under it.
   assign step_tick = frame && active && (count >= (interval - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (frame && active) begin
         count <= step_tick ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/invader_formation.sv
// Invader formation owner: march/drop FSM, alive mask, kills, lives and wave reload.
// Optional INVADER_SPEEDUP_EN makes the step interval track the number of live invaders.
module invader_formation
   import invader_formation_pkg::*;
#(
   parameter int unsigned START_X         = START_X_DEF,
   parameter int unsigned START_Y         = START_Y_DEF,
   parameter int unsigned X_MIN           = X_MIN_DEF,
   parameter int unsigned X_MAX           = X_MAX_DEF,
   parameter int unsigned Y_LAND          = Y_LAND_DEF,
   parameter int unsigned STEP_X          = STEP_X_DEF,
   parameter int unsigned STEP_Y          = STEP_Y_DEF,
   parameter int unsigned FRAMES_PER_STEP = FRAMES_PER_STEP_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame,
   input  logic                  game_start,
   input  logic [COLL_W-1:0]     invader_collision,
   input  logic [1:0]            player_collision,
   output logic [N_INVADERS-1:0] invaders,
   output logic [POS_W-1:0]      invaders_x,
   output logic [POS_W-1:0]      invaders_y,
   output logic [COLL_W-1:0]     alive_count,
   output logic [LIVES_W-1:0]    lives,
   output logic                  laser_hit,
   output logic                  score_inc,
   output logic                  player_hit,
   output logic                  wave_clear,
   output logic                  game_over
);

   localparam logic [POS_W-1:0] START_X_P = POS_W'(START_X);
   localparam logic [POS_W-1:0] START_Y_P = POS_W'(START_Y);
   localparam logic [POS_W-1:0] X_MIN_P   = POS_W'(X_MIN);
   localparam logic [POS_W-1:0] X_MAX_P   = POS_W'(X_MAX);
   localparam logic [POS_W-1:0] Y_LAND_P  = POS_W'(Y_LAND);
   localparam logic [POS_W-1:0] STEP_X_P  = POS_W'(STEP_X);
   localparam logic [POS_W-1:0] STEP_Y_P  = POS_W'(STEP_Y);

   state_t            state;
   logic              dir_right;
   logic              kill_lock;
   logic              hit_lock;
   logic              active_c;
   logic              step_tick_c;
   logic              kill_c;
   logic              hit_c;
   logic [COLL_W-1:0] kill_idx_c;

   assign active_c = is_active(state);

   step_timer #(
      .FRAMES_PER_STEP (FRAMES_PER_STEP)
   ) u_step_timer (
      .clk         (clk),
      .rst         (rst),
      .frame       (frame),
      .active      (active_c),
`ifdef INVADER_SPEEDUP_EN
      .alive_count (alive_count),
`endif
      .step_tick   (step_tick_c)
   );

   // Accept a kill only for a live invader, once per frame; stale codes fall through.
   always_comb begin
      kill_idx_c = invader_collision - COLL_W'(1);
      kill_c     = 1'b0;
      if (active_c && !kill_lock && (invader_collision != '0) &&
          (invader_collision <= COLL_W'(N_INVADERS))) begin
         kill_c = invaders[kill_idx_c];
      end
      hit_c = active_c && !hit_lock && (player_collision != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         dir_right   <= 1'b1;
         kill_lock   <= 1'b0;
         hit_lock    <= 1'b0;
         invaders    <= '1;
         invaders_x  <= START_X_P;
         invaders_y  <= START_Y_P;
         alive_count <= COLL_W'(N_INVADERS);
         lives       <= LIVES_W'(LIVES_INIT);
         laser_hit   <= 1'b0;
         score_inc   <= 1'b0;
         player_hit  <= 1'b0;
         wave_clear  <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         laser_hit  <= 1'b0;
         score_inc  <= 1'b0;
         player_hit <= 1'b0;
         wave_clear <= 1'b0;

         if (kill_c) begin
            invaders    <= invaders & ~(N_INVADERS'(1) << kill_idx_c);
            alive_count <= alive_count - COLL_W'(1);
            laser_hit   <= 1'b1;
            score_inc   <= 1'b1;
         end
         if (hit_c) begin
            lives      <= lives - LIVES_W'(1);
            player_hit <= 1'b1;
         end

         // frame wins over a same-cycle set so the next frame starts unlocked.
         if (frame) begin
            kill_lock <= 1'b0;
            hit_lock  <= 1'b0;
         end else begin
            if (kill_c) kill_lock <= 1'b1;
            if (hit_c)  hit_lock  <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (game_start) state <= ST_MARCH_R;
            end
            ST_MARCH_R, ST_MARCH_L, ST_DROP: begin
               if (hit_c && (lives == LIVES_W'(1))) begin
                  state     <= ST_OVER;
                  game_over <= 1'b1;
               end else if (frame && (alive_count == '0)) begin
                  state       <= ST_CLEAR;
                  wave_clear  <= 1'b1;
                  invaders    <= '1;
                  alive_count <= COLL_W'(N_INVADERS);
                  invaders_x  <= START_X_P;
                  invaders_y  <= START_Y_P;
                  dir_right   <= 1'b1;
               end else if (frame && (invaders_y >= Y_LAND_P)) begin
                  state     <= ST_OVER;
                  game_over <= 1'b1;
               end else if (step_tick_c) begin
                  case (state)
                     ST_MARCH_R: begin
                        if (invaders_x + STEP_X_P > X_MAX_P) begin
                           state      <= ST_DROP;
                           invaders_y <= invaders_y + STEP_Y_P;
                        end else begin
                           invaders_x <= invaders_x + STEP_X_P;
                        end
                     end
                     ST_MARCH_L: begin
                        if (invaders_x < X_MIN_P + STEP_X_P) begin
                           state      <= ST_DROP;
                           invaders_y <= invaders_y + STEP_Y_P;
                        end else begin
                           invaders_x <= invaders_x - STEP_X_P;
                        end
                     end
                     default: begin
                        // Leaving DROP reverses direction and takes the first step that way.
                        if (dir_right) begin
                           state      <= ST_MARCH_L;
                           dir_right  <= 1'b0;
                           invaders_x <= invaders_x - STEP_X_P;
                        end else begin
                           state      <= ST_MARCH_R;
                           dir_right  <= 1'b1;
                           invaders_x <= invaders_x + STEP_X_P;
                        end
                     end
                  endcase
               end
            end
            ST_CLEAR: begin
               state <= ST_MARCH_R;
            end
            default: begin
               game_over <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_invader_formation.sv
// Self-checking bench for invader_formation against a step-count based formation model.
module tb_invader_formation;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame;
   logic        game_start;
   logic [5:0]  invader_collision;
   logic [1:0]  player_collision;
   logic [54:0] invaders;
   logic [9:0]  invaders_x;
   logic [9:0]  invaders_y;
   logic [5:0]  alive_count;
   logic [1:0]  lives;
   logic        laser_hit;
   logic        score_inc;
   logic        player_hit;
   logic        wave_clear;
   logic        game_over;

   invader_formation dut (
      .clk               (clk),
      .rst               (rst),
      .frame             (frame),
      .game_start        (game_start),
      .invader_collision (invader_collision),
      .player_collision  (player_collision),
      .invaders          (invaders),
      .invaders_x        (invaders_x),
      .invaders_y        (invaders_y),
      .alive_count       (alive_count),
      .lives             (lives),
      .laser_hit         (laser_hit),
      .score_inc         (score_inc),
      .player_hit        (player_hit),
      .wave_clear        (wave_clear),
      .game_over         (game_over)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef INVADER_SPEEDUP_EN
   localparam int INIT_INTERVAL = 14;
`else
   localparam int INIT_INTERVAL = 16;
`endif

   localparam int PH_IDLE  = 0;
   localparam int PH_PLAY  = 1;
   localparam int PH_CLEAR = 2;
   localparam int PH_OVER  = 3;

   // Model: game phase, alive set, number of steps walked this wave, lives, per-frame locks.
   logic [54:0] m_mask;
   int          m_steps, m_lives, m_phase, m_fcnt, m_int;
   bit          m_kl, m_hl, e_laser, e_phit, e_wave;

   // Formation origin after n steps, replaying the walk right/drop/left/drop from the start point.
   function automatic void fpos(input int n, output int x, output int y);
      int dir;
      bit dropping;
      dir = 1; dropping = 0; x = 100; y = 64;
      for (int i = 0; i < n; i++) begin
         if (dropping) begin
            dir = -dir; x = x + 2 * dir; dropping = 0;
         end else if ((dir > 0 && x + 2 > 344) || (dir < 0 && x < 18)) begin
            y = y + 8; dropping = 1;
         end else begin
            x = x + 2 * dir;
         end
      end
   endfunction

   task automatic model_reset();
      m_mask = '1; m_steps = 0; m_lives = 3; m_phase = PH_IDLE; m_fcnt = 0;
      m_int = INIT_INTERVAL; m_kl = 0; m_hl = 0; e_laser = 0; e_phit = 0; e_wave = 0;
   endtask

   task automatic model_step(input bit fr, input bit gs, input int ic, input int pc);
      bit play, kill, hit, tick;
      int alive_before, x, y;
      play = (m_phase == PH_PLAY);
      kill = play && !m_kl && ic >= 1 && ic <= 55 && m_mask[ic-1];
      hit  = play && !m_hl && pc != 0;
      tick = play && fr && (m_fcnt + 1 >= m_int);
      alive_before = $countones(m_mask);
      fpos(m_steps, x, y);
      e_laser = kill; e_phit = hit; e_wave = 0;
      if (kill) m_mask[ic-1] = 1'b0;
      if (hit) m_lives = m_lives - 1;
      if (fr) begin m_kl = 0; m_hl = 0; end
      else begin if (kill) m_kl = 1; if (hit) m_hl = 1; end
      if (play && fr) begin
         m_fcnt = tick ? 0 : m_fcnt + 1;
`ifdef INVADER_SPEEDUP_EN
         if (tick) m_int = alive_before / 4 + 1;
`endif
      end
      case (m_phase)
         PH_IDLE:  if (gs) m_phase = PH_PLAY;
         PH_PLAY: begin
            if (hit && m_lives == 0) m_phase = PH_OVER;
            else if (fr && alive_before == 0) begin
               m_phase = PH_CLEAR; m_mask = '1; m_steps = 0; e_wave = 1;
            end else if (fr && y >= 400) m_phase = PH_OVER;
            else if (tick) m_steps = m_steps + 1;
         end
         PH_CLEAR: m_phase = PH_PLAY;
         default: ;
      endcase
   endtask

   task automatic cyc(input bit fr, input bit gs, input logic [5:0] ic, input logic [1:0] pc);
      frame = fr; game_start = gs; invader_collision = ic; player_collision = pc;
      model_step(fr, gs, int'(ic), int'(pc));
      @(posedge clk); #1;
      frame = 0; game_start = 0; invader_collision = '0; player_collision = '0;
   endtask

   task automatic do_reset();
      rst = 1; frame = 0; game_start = 0; invader_collision = '0; player_collision = '0;
      model_reset();
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (invaders !== '1) begin n_bad++; $display("FAIL reset_mask: got %h expected all ones", invaders); end
      n_cmp++; if (invaders_x !== 10'd100) begin n_bad++; $display("FAIL reset_x: got %0d expected 100", invaders_x); end
      n_cmp++; if (invaders_y !== 10'd64) begin n_bad++; $display("FAIL reset_y: got %0d expected 64", invaders_y); end
      n_cmp++; if (alive_count !== 6'd55) begin n_bad++; $display("FAIL reset_alive: got %0d expected 55", alive_count); end
      n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL reset_lives: got %0d expected 3", lives); end
      n_cmp++; if ({laser_hit, score_inc, player_hit, wave_clear, game_over} !== 5'b0) begin
         n_bad++; $display("FAIL reset_pulses: got %b expected 00000", {laser_hit, score_inc, player_hit, wave_clear, game_over});
      end
      // Reset asserted together with a kill, a hit and a frame must win outright.
      cyc(0, 1, 6'd0, 2'd0);
      rst = 1; frame = 1; invader_collision = 6'd7; player_collision = 2'd1;
      model_reset();
      @(posedge clk); #1;
      rst = 0; frame = 0; invader_collision = '0; player_collision = '0;
      n_cmp++; if (invaders !== '1 || alive_count !== 6'd55 || laser_hit !== 1'b0 || lives !== 2'd3) begin
         n_bad++; $display("FAIL reset_mid_kill: got mask %h alive %0d laser %b lives %0d expected all ones 55 0 3", invaders, alive_count, laser_hit, lives);
      end
   endtask

   task automatic test_march();
      cyc(0, 1, 6'd0, 2'd0);
      for (int i = 1; i <= INIT_INTERVAL; i++) begin
         cyc(1, 0, 6'd0, 2'd0);
         cyc(0, 0, 6'd0, 2'd0);
         if (i == INIT_INTERVAL - 1) begin
            n_cmp++; if (invaders_x !== 10'd100) begin n_bad++; $display("FAIL march_before_tick: got %0d expected 100", invaders_x); end
         end
      end
      n_cmp++; if (invaders_x !== 10'd102) begin n_bad++; $display("FAIL march_first_step: got %0d expected 102", invaders_x); end
      n_cmp++; if (alive_count !== 6'd55) begin n_bad++; $display("FAIL march_alive: got %0d expected 55", alive_count); end
   endtask

   task automatic test_kill();
      int pulses, scores;
      pulses = 0; scores = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 6'd12, 2'd0);
         if (laser_hit === 1'b1) pulses++;
         if (score_inc === 1'b1 && laser_hit === 1'b1) scores++;
      end
      n_cmp++; if (pulses != 1 || scores != 1) begin n_bad++; $display("FAIL kill_pulses: got %0d laser %0d score expected 1 1", pulses, scores); end
      n_cmp++; if (invaders[11] !== 1'b0) begin n_bad++; $display("FAIL kill_bit11: got %b expected 0", invaders[11]); end
      n_cmp++; if (alive_count !== 6'd54) begin n_bad++; $display("FAIL kill_alive: got %0d expected 54", alive_count); end
      cyc(1, 0, 6'd0, 2'd0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 6'd12, 2'd0);
         if (laser_hit !== 1'b0) pulses++;
      end
      n_cmp++; if (pulses != 0 || alive_count !== 6'd54) begin n_bad++; $display("FAIL kill_stale: got %0d pulses alive %0d expected 0 54", pulses, alive_count); end
   endtask

   task automatic test_edge_drop();
      int mx, my, guard;
      guard = 0;
      fpos(m_steps, mx, my);
      while (mx != 344 && guard < 4000) begin
         cyc(1, 0, 6'd0, 2'd0); fpos(m_steps, mx, my); guard++;
      end
      n_cmp++; if (invaders_x !== 10'd344 || guard >= 4000) begin n_bad++; $display("FAIL edge_reach: got %0d expected 344", invaders_x); end
      guard = 0;
      while (my == 64 && guard < 40) begin cyc(1, 0, 6'd0, 2'd0); fpos(m_steps, mx, my); guard++; end
      n_cmp++; if (invaders_y !== 10'd72 || invaders_x !== 10'd344) begin
         n_bad++; $display("FAIL edge_drop: got (%0d,%0d) expected (344,72)", invaders_x, invaders_y);
      end
      guard = 0;
      while (mx == 344 && guard < 40) begin cyc(1, 0, 6'd0, 2'd0); fpos(m_steps, mx, my); guard++; end
      n_cmp++; if (invaders_x !== 10'd342 || invaders_y !== 10'd72) begin
         n_bad++; $display("FAIL edge_reverse: got (%0d,%0d) expected (342,72)", invaders_x, invaders_y);
      end
   endtask

   task automatic test_clear();
      do_reset();
      cyc(0, 1, 6'd0, 2'd0);
      for (int k = 1; k <= 55; k++) cyc(1, 0, 6'(k), 2'd0);
      n_cmp++; if (alive_count !== 6'd0 || invaders !== '0) begin n_bad++; $display("FAIL clear_all_dead: got alive %0d mask %h expected 0 0", alive_count, invaders); end
      cyc(1, 0, 6'd0, 2'd0);
      n_cmp++; if (wave_clear !== 1'b1) begin n_bad++; $display("FAIL clear_pulse: got %b expected 1", wave_clear); end
      n_cmp++; if (invaders !== '1 || alive_count !== 6'd55) begin n_bad++; $display("FAIL clear_reload: got mask %h alive %0d expected all ones 55", invaders, alive_count); end
      n_cmp++; if (invaders_x !== 10'd100 || invaders_y !== 10'd64) begin n_bad++; $display("FAIL clear_origin: got (%0d,%0d) expected (100,64)", invaders_x, invaders_y); end
      cyc(0, 0, 6'd0, 2'd0);
      n_cmp++; if (wave_clear !== 1'b0) begin n_bad++; $display("FAIL clear_width: got %b expected 0", wave_clear); end
   endtask

   task automatic test_player();
      int hits;
      hits = 0;
      do_reset();
      cyc(0, 1, 6'd0, 2'd0);
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 6'd0, 2'd2);
            if (player_hit === 1'b1) hits++;
         end
         if (f == 0) begin
            n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL player_first: got %0d lives expected 2", lives); end
         end
         cyc(1, 0, 6'd0, 2'd0);
      end
      n_cmp++; if (hits != 3) begin n_bad++; $display("FAIL player_pulses: got %0d expected 3", hits); end
      n_cmp++; if (lives !== 2'd0 || game_over !== 1'b1) begin n_bad++; $display("FAIL player_over: got lives %0d over %b expected 0 1", lives, game_over); end
   endtask

`ifdef INVADER_SPEEDUP_EN
   task automatic test_speedup();
      int mx, my, prev;
      do_reset();
      cyc(0, 1, 6'd0, 2'd0);
      for (int k = 1; k <= 52; k++) cyc(1, 0, 6'(k), 2'd0);
      for (int i = 0; i < 20; i++) cyc(1, 0, 6'd0, 2'd0);
      for (int i = 0; i < 4; i++) begin
         fpos(m_steps, prev, my);
         cyc(1, 0, 6'd0, 2'd0);
         fpos(m_steps, mx, my);
         n_cmp++; if (int'(invaders_x) != mx || int'(invaders_y) != my || m_steps == 0) begin
            n_bad++; $display("FAIL speedup_step: got (%0d,%0d) expected (%0d,%0d)", invaders_x, invaders_y, mx, my);
         end
      end
   endtask
`endif

   task automatic test_random();
      int mx, my;
      do_reset();
      cyc(0, 1, 6'd0, 2'd0);
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         else cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63)),
                  ($urandom_range(0, 899) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
         fpos(m_steps, mx, my);
         n_cmp++; if (invaders !== m_mask) begin n_bad++; $display("FAIL rnd_mask@%0d: got %h expected %h", i, invaders, m_mask); end
         n_cmp++; if (int'(invaders_x) != mx || int'(invaders_y) != my) begin
            n_bad++; $display("FAIL rnd_origin@%0d: got (%0d,%0d) expected (%0d,%0d)", i, invaders_x, invaders_y, mx, my);
         end
         n_cmp++; if (int'(alive_count) != $countones(m_mask)) begin n_bad++; $display("FAIL rnd_alive@%0d: got %0d expected %0d", i, alive_count, $countones(m_mask)); end
         n_cmp++; if (int'(lives) != m_lives) begin n_bad++; $display("FAIL rnd_lives@%0d: got %0d expected %0d", i, lives, m_lives); end
         n_cmp++; if ({laser_hit, score_inc, player_hit, wave_clear, game_over} !==
                      {e_laser, e_laser, e_phit, e_wave, (m_phase == PH_OVER)}) begin
            n_bad++; $display("FAIL rnd_flags@%0d: got %b expected %b", i, {laser_hit, score_inc, player_hit, wave_clear, game_over},
                              {e_laser, e_laser, e_phit, e_wave, (m_phase == PH_OVER)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_march();
      test_kill();
      test_edge_drop();
      test_clear();
      test_player();
`ifdef INVADER_SPEEDUP_EN
      test_speedup();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
